threebit_seq_adder: RTL and testbench

Sequencer that performs a W = 3*NCHUNK bit addition by time-multiplexing one external combinational 3-bit adder (no carry-in; outputs 3-bit sum and carry-out). The adder is processed one 3-bit chunk per step, LSB chunk first. Carries between chunks are applied as a separate "+1" pass through the same adder. Sits between a requester issuing start/operands and the shared threebit adder instance.

---
 rtl/threebit_seq_adder_if.sv | 19 +
 rtl/threebit_seq_adder.sv | 136 +++++++++++++
 tb/tb_threebit_seq_adder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/threebit_seq_adder_if.sv
// Requester-side bundle for the chunked sequential adder: start/operands in,
// busy/done/result back.
interface threebit_seq_adder_if #(
    parameter int NCHUNK = 4
);
    localparam int W = 3 * NCHUNK;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/threebit_seq_adder.sv
// W = 3*NCHUNK bit adder built by time-multiplexing one external 3-bit adder,
// LSB chunk first, with inter-chunk carries applied as a separate +1 pass.
module threebit_seq_adder #(
    parameter int NCHUNK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    threebit_seq_adder_if.slave   req,
    output logic [2:0]            add_x,
    output logic [2:0]            add_y,
    input  logic [2:0]            add_s,
    input  logic                  add_c
);
    localparam int W  = 3 * NCHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, ADD, CARRY, DONE} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    a_reg, b_reg;
    logic [2:0]      sum_reg [NCHUNK];
    logic [2:0]      a_chunk [NCHUNK];
    logic [2:0]      b_chunk [NCHUNK];
    logic [IW-1:0]   idx_reg, idx_next;
    logic            pend_reg, pend_next;
    logic            c1_reg, c1_next;
    logic            cout_reg;
    logic            load;
    logic            wr_en;
    logic            last;

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[3*gi +: 3];
            assign b_chunk[gi] = b_reg[3*gi +: 3];
            assign req.sum[3*gi +: 3] = sum_reg[gi];

            // Each chunk of the result owns its own register; only the active one is written.
            always_ff @(posedge clk) begin
                if (rst || load) begin
                    sum_reg[gi] <= 3'b000;
                end else if (wr_en && (idx_reg == IW'(gi))) begin
                    sum_reg[gi] <= add_s;
                end
            end
        end
    endgenerate

    assign last = (idx_reg == IW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            pend_reg  <= 1'b0;
            c1_reg    <= 1'b0;
            cout_reg  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            pend_reg  <= pend_next;
            c1_reg    <= c1_next;
            if (load) begin
                a_reg    <= req.a;
                b_reg    <= req.b;
                cout_reg <= 1'b0;
            end else if (state_reg == DONE) begin
                cout_reg <= pend_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        pend_next  = pend_reg;
        c1_next    = c1_reg;
        add_x      = 3'b000;
        add_y      = 3'b000;
        load       = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req.start) begin
                    load       = 1'b1;
                    idx_next   = '0;
                    pend_next  = req.cin;
                    state_next = ADD;
                end
            end
            ADD: begin
                add_x   = a_chunk[idx_reg];
                add_y   = b_chunk[idx_reg];
                wr_en   = 1'b1;
                c1_next = add_c;
                if (pend_reg) begin
                    state_next = CARRY;
                end else begin
                    pend_next = add_c;
                    if (last) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ADD;
                    end
                end
            end
            CARRY: begin
                add_x     = sum_reg[idx_reg];
                add_y     = 3'b001;
                wr_en     = 1'b1;
                // The chunk add and the +1 pass can never both overflow.
                pend_next = c1_reg | add_c;
                if (last) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    state_next = ADD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign req.busy = (state_reg != IDLE);
    assign req.done = (state_reg == DONE);
    assign req.cout = (state_reg == DONE) ? pend_reg : cout_reg;
endmodule

// File: tb/tb_threebit_seq_adder.sv
// Scoreboard bench for threebit_seq_adder with a behavioural 3-bit adder attached.
module tb_threebit_seq_adder;
    localparam int NCHUNK = 4;
    localparam int W      = 3 * NCHUNK;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        int           lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [2:0] add_x, add_y, add_s;
    logic       add_c;

    threebit_seq_adder_if #(.NCHUNK(NCHUNK)) req ();

    threebit_seq_adder #(.NCHUNK(NCHUNK)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .add_x (add_x),
        .add_y (add_y),
        .add_s (add_s),
        .add_c (add_c)
    );

    assign {add_c, add_s} = {1'b0, add_x} + {1'b0, add_y};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    always @(negedge clk) if (req.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int carries = 0;
        for (int i = 0; i < NCHUNK; i++) begin
            logic [63:0] mask = (64'd1 << (3*i)) - 64'd1;
            logic [63:0] part = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
            if (part[3*i]) carries++;
        end
        return NCHUNK + carries + 1;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input bit inject);
        exp_t          e;
        exp_t          got;
        logic [W+1:0]  full;
        int            lat;
        int            cnt0;
        bit            seen;
        @(negedge clk);
        full     = {2'b00, a} + {2'b00, b} + {{(W+1){1'b0}}, cin};
        e.sum    = full[W-1:0];
        e.cout   = full[W];
        e.lat    = exp_latency(a, b, cin);
        cnt0     = done_cnt;
        req.start = 1'b1; req.a = a; req.b = b; req.cin = cin;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req.start = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (req.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (inject && k == 1) begin
                req.start = 1'b1; req.a = 12'h555; req.b = 12'h555; req.cin = 1'b1;
            end else begin
                req.start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = sb.pop_front();
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
            req.start = 1'b0;
            return;
        end
        check("latency", 64'(lat), 64'(got.lat));
        check("sum", 64'(req.sum), 64'(got.sum));
        check("cout", 64'(req.cout), 64'(got.cout));
        check("busy_in_done", 64'(req.busy), 64'd1);
        if (inject) begin
            req.start = 1'b1; req.a = 12'h555; req.b = 12'h000; req.cin = 1'b0;
        end
        @(posedge clk);
        #1;
        req.start = 1'b0;
        check("done_pulse", 64'(req.done), 64'd0);
        check("busy_after", 64'(req.busy), 64'd0);
        check("sum_held", 64'(req.sum), 64'(got.sum));
        check("cout_held", 64'(req.cout), 64'(got.cout));
        if (inject) begin
            repeat (3) @(posedge clk);
            #1;
            check("ignored_start_idle", 64'(req.busy), 64'd0);
            check("ignored_start_sum", 64'(req.sum), 64'(got.sum));
        end
        check("done_count", 64'(done_cnt - cnt0), 64'd1);
        $display("op a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d (exp sum=%h cout=%0d lat=%0d)",
                 a, b, cin, req.sum, req.cout, lat, got.sum, got.cout, got.lat);
    endtask

    initial begin
        int cnt0;
        rst = 1'b1; req.start = 1'b0; req.a = '0; req.b = '0; req.cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(req.busy), 64'd0);
        check("rst_done", 64'(req.done), 64'd0);
        check("rst_sum", 64'(req.sum), 64'd0);
        check("rst_cout", 64'(req.cout), 64'd0);
        check("rst_add_x", 64'(add_x), 64'd0);
        rst = 1'b0;

        run_op(12'h000, 12'h000, 1'b0, 1'b0);
        run_op(12'h007, 12'h001, 1'b0, 1'b0);
        run_op(12'hFFF, 12'h001, 1'b0, 1'b0);
        run_op(12'hFFF, 12'h000, 1'b1, 1'b0);
        run_op(12'hABC, 12'h123, 1'b0, 1'b0);
        run_op(12'h0F0, 12'h00F, 1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        // Abort mid-operation: accept edge is 1, reset sampled at edge 3.
        @(negedge clk);
        req.start = 1'b1; req.a = 12'hFFF; req.b = 12'h000; req.cin = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(req.busy), 64'd0);
        check("abort_done", 64'(req.done), 64'd0);
        check("abort_sum", 64'(req.sum), 64'd0);
        check("abort_cout", 64'(req.cout), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - cnt0), 64'd0);
        $display("op abort: busy=%0d done=%0d sum=%h", req.busy, req.done, req.sum);
        run_op(12'h001, 12'h002, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
